// File: rtl/timer_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_unit_if
// Description : Bus bundle between the ALU and the elapsed-time timer. The
//               ALU (master) issues START and reads the registered count,
//               running and overflow status; the timer is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_unit_if;
    logic        start;
    logic [15:0] timer;
    logic        running;
    logic        overflow;

    modport master (
        output start,
        input  timer,
        input  running,
        input  overflow
    );

    modport slave (
        input  start,
        output timer,
        output running,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/timer_unit.sv
`default_nettype none
// ============================================================================
// Module      : timer_unit
// Description : Elapsed-time timer. A 16-bit prescale counter divides clk by
//               PRESCALE; each prescale terminal count advances the 16-bit
//               timer. START (from any state) clears everything and runs.
//               Compile-time macro TIMER_WRAP_EN selects the 16'hFFFF
//               terminal behaviour:
//                 defined   - timer wraps to 0, overflow set, keeps running
//                 undefined - timer saturates at 16'hFFFF, overflow set,
//                             state moves to HALTED
// Revision    : 1.0 - initial release
// ============================================================================
module timer_unit #(
    parameter int unsigned PRESCALE = 50     // clk cycles per timer increment, 1..65535
) (
    input  wire logic     clk,
    input  wire logic     reset,
    timer_unit_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  c_ST_IDLE    = 2'd0;
    localparam logic [1:0]  c_ST_RUNNING = 2'd1;
    localparam logic [1:0]  c_ST_HALTED  = 2'd2;

    localparam logic [15:0] c_PRESC_LAST = 16'(PRESCALE - 1);
    localparam logic [15:0] c_TIMER_MAX  = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_presc;
    logic [15:0] r_timer;
    logic        r_ovf;

    logic        w_start;
    logic        w_running;
    logic        w_tick;      // prescaler at terminal count this cycle
    logic        w_term;      // timer increment out of 16'hFFFF this cycle

    assign w_start   = bus.start;
    assign w_running = (r_state == c_ST_RUNNING);
    assign w_tick    = w_running && (r_presc == c_PRESC_LAST);
    assign w_term    = w_tick && (r_timer == c_TIMER_MAX);

    // Next-state decode; start wins over everything except reset, which is
    // applied in the state register itself.
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = c_ST_RUNNING;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_state_nxt = c_ST_IDLE;
                end
                c_ST_RUNNING: begin
`ifdef TIMER_WRAP_EN
                    // Wrapping keeps the timer running past 16'hFFFF.
                    w_state_nxt = c_ST_RUNNING;
`else
                    // Saturating build stops on the terminal increment.
                    if (w_term) begin
                        w_state_nxt = c_ST_HALTED;
                    end
`endif
                end
                c_ST_HALTED: begin
                    w_state_nxt = c_ST_HALTED;
                end
                default: begin
                    // Unused encoding: recover to a safe state.
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // State register; reset has priority over a simultaneous start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Prescale counter: cleared by start, free-runs modulo PRESCALE while
    // running, holds in IDLE and HALTED.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= 16'd0;
        end else if (w_start) begin
            r_presc <= 16'd0;
        end else if (w_running) begin
            if (r_presc == c_PRESC_LAST) begin
                r_presc <= 16'd0;
            end else begin
                r_presc <= r_presc + 16'd1;
            end
        end
    end

    // Elapsed-time counter: advances on each prescale terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= 16'd0;
        end else if (w_start) begin
            r_timer <= 16'd0;
        end else if (w_tick) begin
            if (w_term) begin
`ifdef TIMER_WRAP_EN
                r_timer <= 16'd0;
`else
                r_timer <= c_TIMER_MAX;
`endif
            end else begin
                r_timer <= r_timer + 16'd1;
            end
        end
    end

    // Sticky overflow: set by any increment out of 16'hFFFF, cleared by start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_start) begin
            r_ovf <= 1'b0;
        end else if (w_term) begin
            r_ovf <= 1'b1;
        end
    end

    // Outputs: count and overflow straight from registers; running is a
    // pure decode of the state register.
    assign bus.timer    = r_timer;
    assign bus.overflow = r_ovf;
    assign bus.running  = w_running;

endmodule
`default_nettype wire

// File: tb/tb_timer_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_unit
// Description : Scoreboard bench for timer_unit. Two instances (PRESCALE=4
//               and PRESCALE=1) share the same reset/start stimulus. An
//               elapsed-cycle reference model produces the expected outputs
//               after every edge; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    timer_unit_if bus4();
    timer_unit_if bus1();

    timer_unit #(.PRESCALE(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    timer_unit #(.PRESCALE(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    typedef struct {
        logic [15:0] t;
        logic        r;
        logic        o;
        bit          chk;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: per instance a mode (0 idle, 1 running, 2 halted)
    // and the number of counting edges since the last start.
    int m_mode [2];
    int m_cnt  [2];

    function automatic int presc_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic exp_t model_out(input int k, input bit chk);
        exp_t e;
        int   n;
        n = m_cnt[k] / presc_of(k);
`ifdef TIMER_WRAP_EN
        e.t = 16'(n % 65536);
`else
        e.t = (n > 65535) ? 16'hFFFF : 16'(n);
`endif
        e.o   = (n >= 65536);
        e.r   = (m_mode[k] == 1);
        e.chk = chk;
        return e;
    endfunction

    task automatic model_step(input bit r, input bit s);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_mode[k] = 0;
                m_cnt[k]  = 0;
            end else if (s) begin
                m_mode[k] = 1;
                m_cnt[k]  = 0;
            end else if (m_mode[k] == 1) begin
                m_cnt[k] = m_cnt[k] + 1;
`ifndef TIMER_WRAP_EN
                if (m_cnt[k] / presc_of(k) >= 65536) m_mode[k] = 2;
`endif
            end
        end
    endtask

    // One clock: apply inputs, let the edge happen, then record expectations.
    task automatic cyc(input bit r, input bit s, input bit chk);
        reset      = r;
        bus4.start = s;
        bus1.start = s;
        @(posedge clk);
        #1;
        model_step(r, s);
        q4.push_back(model_out(0, chk));
        q1.push_back(model_out(1, chk));
    endtask

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                if (e.chk) begin
                    cmp("p4.timer",    bus4.timer,           e.t);
                    cmp("p4.running",  16'(bus4.running),    16'(e.r));
                    cmp("p4.overflow", 16'(bus4.overflow),   16'(e.o));
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                if (e.chk) begin
                    cmp("p1.timer",    bus1.timer,           e.t);
                    cmp("p1.running",  16'(bus1.running),    16'(e.r));
                    cmp("p1.overflow", 16'(bus1.overflow),   16'(e.o));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        m_mode[0] = 0; m_mode[1] = 0;
        m_cnt[0]  = 0; m_cnt[1]  = 0;
        reset      = 1'b1;
        bus4.start = 1'b0;
        bus1.start = 1'b0;

        // Reset two cycles, then idle.
        repeat (2)  cyc(1'b1, 1'b0, 1'b1);
        repeat (10) cyc(1'b0, 1'b0, 1'b1);

        // Single start pulse, count well past the fifth increment.
        cyc(1'b0, 1'b1, 1'b1);
        repeat (24) cyc(1'b0, 1'b0, 1'b1);

        // Restart mid-count once the slow timer reaches 3.
        cyc(1'b0, 1'b1, 1'b1);
        guard = 0;
        while (model_out(0, 1'b1).t != 16'd3 && guard < 100) begin
            cyc(1'b0, 1'b0, 1'b1);
            guard++;
        end
        cyc(1'b0, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 1'b0, 1'b1);

        // Reset and start together: reset must win.
        cyc(1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);

        // Reset while the slow timer reads 7, then a fresh start.
        cyc(1'b0, 1'b1, 1'b1);
        guard = 0;
        while (model_out(0, 1'b1).t != 16'd7 && guard < 100) begin
            cyc(1'b0, 1'b0, 1'b1);
            guard++;
        end
        cyc(1'b1, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 1'b0, 1'b1);

        // Random start/reset traffic.
        repeat (3000) cyc($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, 1'b1);

        // Start held five cycles, then released.
        repeat (5) cyc(1'b0, 1'b1, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 1'b1);

        // Terminal count on the PRESCALE=1 instance; sparse checks mid-run,
        // every cycle around the 16'hFFFF crossing.
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 65541; i++) begin
            cyc(1'b0, 1'b0, (i % 4096 == 0) || (i > 65528));
        end
        cyc(1'b0, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);

        // Drain the scoreboard.
        guard = 0;
        while ((q4.size() > 0 || q1.size() > 0) && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (q4.size() > 0 || q1.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d entries pending expected 0", q4.size() + q1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
